// File: rtl/match_resp_reorder_pkg.sv
// match_resp_reorder_pkg
// Shared match-path sizing for the job PE response logic. It provides the
// lazy-match slot count, the response channel count, the match length width,
// and the depth of the outstanding-group reorder buffer.
package match_resp_reorder_pkg;

  localparam int LAZY_LEN         = 4;
  localparam int LAZY_LEN_LOG2    = 2;
  localparam int NUM_MATCH_REQ_CH = 2;
  localparam int MATCH_LEN_WIDTH  = 8;
  localparam int MATCH_RESP_DEPTH = 4;

endpackage

// File: rtl/match_resp_reorder_if.sv
// match_resp_reorder_if
// Bundle of signals between the match request dispatcher / match channels
// and job_pe.
//   group allocation : req_group_valid/ready/strb/id
//   match responses  : resp_valid/ready/gid/tag/match_len (C channels, packed)
//   group release    : resp_group_valid/ready/match_len
//   err              : sticky protocol error
// The slave modport is the reorder block; the master modport is its environment.
interface match_resp_reorder_if #(
  parameter int L        = match_resp_reorder_pkg::LAZY_LEN,
  parameter int C        = match_resp_reorder_pkg::NUM_MATCH_REQ_CH,
  parameter int TAG_BITS = match_resp_reorder_pkg::LAZY_LEN_LOG2,
  parameter int GID_BITS = $clog2(match_resp_reorder_pkg::MATCH_RESP_DEPTH),
  parameter int ML       = match_resp_reorder_pkg::MATCH_LEN_WIDTH
);

  logic                  req_group_valid;
  logic                  req_group_ready;
  logic [L-1:0]          req_group_strb;
  logic [GID_BITS-1:0]   req_group_id;

  logic [C-1:0]          resp_valid;
  logic [C-1:0]          resp_ready;
  logic [C*GID_BITS-1:0] resp_gid;
  logic [C*TAG_BITS-1:0] resp_tag;
  logic [C*ML-1:0]       resp_match_len;

  logic                  resp_group_valid;
  logic                  resp_group_ready;
  logic [L*ML-1:0]       resp_group_match_len;

  logic                  err;

  modport slave (
    input  req_group_valid, req_group_strb,
    output req_group_ready, req_group_id,
    input  resp_valid, resp_gid, resp_tag, resp_match_len,
    output resp_ready,
    output resp_group_valid, resp_group_match_len,
    input  resp_group_ready,
    output err
  );

  modport master (
    output req_group_valid, req_group_strb,
    input  req_group_ready, req_group_id,
    output resp_valid, resp_gid, resp_tag, resp_match_len,
    input  resp_ready,
    input  resp_group_valid, resp_group_match_len,
    output resp_group_ready,
    input  err
  );

endinterface

// File: rtl/match_resp_entry.sv
// match_resp_entry
// One outstanding group slot of the reorder buffer. It holds the per-slot
// done flags, the per-slot match lengths and the allocated flag.
//   alloc_en/alloc_strb : load a new group; unrequested slots start done
//   rel_en              : group handed to job_pe, entry becomes free
//   hit/hit_tag/hit_len : channels whose accepted response targets this entry
//   done/lens/alloc     : stored state
//   legal               : per channel, whether its tag may be written here
module match_resp_entry import match_resp_reorder_pkg::*; #(
  parameter int L        = LAZY_LEN,
  parameter int C        = NUM_MATCH_REQ_CH,
  parameter int TAG_BITS = LAZY_LEN_LOG2,
  parameter int ML       = MATCH_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_en,
  input  logic [L-1:0]          alloc_strb,
  input  logic                  rel_en,
  input  logic [C-1:0]          hit,
  input  logic [C*TAG_BITS-1:0] hit_tag,
  input  logic [C*ML-1:0]       hit_len,
  output logic [L-1:0]          done,
  output logic [L*ML-1:0]       lens,
  output logic                  alloc,
  output logic [C-1:0]          legal
);

  logic [TAG_BITS-1:0] tag_w [C];

  for (genvar j = 0; j < C; j++) begin : g_tag
    assign tag_w[j] = hit_tag[j*TAG_BITS +: TAG_BITS];
  end

  always_comb begin
    legal = '0;
    for (int j = 0; j < C; j++) begin
      legal[j] = alloc && !done[tag_w[j]];
    end
  end

  // The top only raises hit for legal, de-duplicated channels, so every hit
  // in a cycle targets a distinct slot of an already-allocated entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      done  <= '0;
      lens  <= '0;
      alloc <= 1'b0;
    end else if (alloc_en) begin
      done  <= ~alloc_strb;
      lens  <= '0;
      alloc <= 1'b1;
    end else begin
      if (rel_en) begin
        alloc <= 1'b0;
      end
      for (int j = 0; j < C; j++) begin
        if (hit[j]) begin
          done[tag_w[j]]                 <= 1'b1;
          lens[int'(tag_w[j])*ML +: ML] <= hit_len[j*ML +: ML];
        end
      end
    end
  end

endmodule

// File: rtl/match_resp_reorder.sv
// match_resp_reorder
// Tracks up to D in-flight lazy-match groups for one job PE. It collects
// out-of-order responses from C match channels and releases completed groups
// to job_pe strictly in allocation order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : allocation, response and release handshakes plus err
module match_resp_reorder import match_resp_reorder_pkg::*; #(
  parameter int JOB_PE_IDX = 0,
  parameter int L          = LAZY_LEN,
  parameter int C          = NUM_MATCH_REQ_CH,
  parameter int D          = MATCH_RESP_DEPTH,
  parameter int TAG_BITS   = LAZY_LEN_LOG2,
  parameter int GID_BITS   = $clog2(D),
  parameter int ML         = MATCH_LEN_WIDTH
) (
  input  logic clk,
  input  logic rst,
  match_resp_reorder_if.slave bus
);

  localparam logic [GID_BITS:0] COUNT_FULL = (GID_BITS+1)'(D);

  logic [GID_BITS-1:0] head;
  logic [GID_BITS-1:0] tail;
  logic [GID_BITS:0]   count;
  logic                err_q;

  logic                full;
  logic                head_valid;
  logic                alloc_fire;
  logic                rel_fire;
  logic                err_set;
  logic [C-1:0]        accept;

  logic [GID_BITS-1:0] gid_ch  [C];
  logic [TAG_BITS-1:0] tag_ch  [C];
  logic [L-1:0]        done_e  [D];
  logic [L*ML-1:0]     len_e   [D];
  logic [D-1:0]        alloc_e;
  logic [C-1:0]        legal_e [D];
  logic [C-1:0]        win_e   [D];

  assign full       = (count == COUNT_FULL);
  // The head entry is allocated exactly when count is non-zero.
  assign head_valid = alloc_e[head] && (&done_e[head]);
  assign alloc_fire = bus.req_group_valid && !full;
  assign rel_fire   = head_valid && bus.resp_group_ready;

  assign bus.resp_ready           = '1;
  assign bus.req_group_ready      = !full;
  assign bus.req_group_id         = tail;
  assign bus.resp_group_valid     = head_valid;
  assign bus.resp_group_match_len = len_e[head];
  assign bus.err                  = err_q;

  for (genvar j = 0; j < C; j++) begin : g_ch
    assign gid_ch[j] = bus.resp_gid[j*GID_BITS +: GID_BITS];
    assign tag_ch[j] = bus.resp_tag[j*TAG_BITS +: TAG_BITS];
  end

  // A channel is accepted when its slot is open and no lower-indexed channel
  // targets the same gid/tag this cycle; anything else only flags err.
  always_comb begin
    logic clash;
    accept  = '0;
    err_set = 1'b0;
    clash   = 1'b0;
    for (int j = 0; j < C; j++) begin
      if (bus.resp_valid[j]) begin
        clash = 1'b0;
        for (int k = 0; k < j; k++) begin
          if (bus.resp_valid[k] && gid_ch[k] == gid_ch[j] && tag_ch[k] == tag_ch[j]) begin
            clash = 1'b1;
          end
        end
        if (legal_e[gid_ch[j]][j] && !clash) begin
          accept[j] = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int e = 0; e < D; e++) begin
      win_e[e] = '0;
      for (int j = 0; j < C; j++) begin
        win_e[e][j] = accept[j] && (gid_ch[j] == GID_BITS'(e));
      end
    end
  end

  for (genvar e = 0; e < D; e++) begin : g_ent
    match_resp_entry #(
      .L        (L),
      .C        (C),
      .TAG_BITS (TAG_BITS),
      .ML       (ML)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .alloc_en   (alloc_fire && (tail == GID_BITS'(e))),
      .alloc_strb (bus.req_group_strb),
      .rel_en     (rel_fire && (head == GID_BITS'(e))),
      .hit        (win_e[e]),
      .hit_tag    (bus.resp_tag),
      .hit_len    (bus.resp_match_len),
      .done       (done_e[e]),
      .lens       (len_e[e]),
      .alloc      (alloc_e[e]),
      .legal      (legal_e[e])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      if (alloc_fire) begin
        tail <= tail + 1'b1;
      end
      if (rel_fire) begin
        head <= head + 1'b1;
      end
      case ({alloc_fire, rel_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef JOB_PE_DEBUG_LOG
  always @(posedge clk) begin
    if (!rst) begin
      if (alloc_fire) $display("[job_pe %0d] match group alloc gid=%0d", JOB_PE_IDX, tail);
      if (rel_fire)   $display("[job_pe %0d] match group release gid=%0d", JOB_PE_IDX, head);
      if (err_set)    $display("[job_pe %0d] match response protocol error", JOB_PE_IDX);
    end
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^JOB_PE_IDX;
`endif

endmodule

// File: tb/tb_match_resp_reorder.sv
module tb_match_resp_reorder;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  match_resp_reorder_if bus ();

  match_resp_reorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_group_valid  = 1'b0;
    bus.req_group_strb   = '0;
    bus.resp_valid       = '0;
    bus.resp_gid         = '0;
    bus.resp_tag         = '0;
    bus.resp_match_len   = '0;
    bus.resp_group_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] strb, input logic [1:0] exp_id);
    bus.req_group_valid = 1'b1;
    bus.req_group_strb  = strb;
    chk("alloc_ready", 32'(bus.req_group_ready), 32'd1);
    chk("alloc_id", 32'(bus.req_group_id), 32'(exp_id));
    tick();
    bus.req_group_valid = 1'b0;
    bus.req_group_strb  = '0;
  endtask

  task automatic resp(input logic [1:0] v,
                      input logic [1:0] g0, input logic [1:0] t0, input logic [7:0] l0,
                      input logic [1:0] g1, input logic [1:0] t1, input logic [7:0] l1);
    bus.resp_valid     = v;
    bus.resp_gid       = {g1, g0};
    bus.resp_tag       = {t1, t0};
    bus.resp_match_len = {l1, l0};
    tick();
    bus.resp_valid = '0;
  endtask

  initial begin
    do_reset();

    // reset values
    chk("rst_req_ready", 32'(bus.req_group_ready), 32'd1);
    chk("rst_req_id", 32'(bus.req_group_id), 32'd0);
    chk("rst_grp_valid", 32'(bus.resp_group_valid), 32'd0);
    chk("rst_grp_len", bus.resp_group_match_len, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_resp_ready", 32'(bus.resp_ready), 32'd3);

    // single group, responses in scrambled slot order
    alloc(4'b1111, 2'd0);
    resp(2'b01, 2'd0, 2'd2, 8'd5, 2'd0, 2'd0, 8'd0);
    chk("s1_valid_a", 32'(bus.resp_group_valid), 32'd0);
    resp(2'b01, 2'd0, 2'd0, 8'd7, 2'd0, 2'd0, 8'd0);
    chk("s1_valid_b", 32'(bus.resp_group_valid), 32'd0);
    resp(2'b01, 2'd0, 2'd3, 8'd0, 2'd0, 2'd0, 8'd0);
    chk("s1_valid_c", 32'(bus.resp_group_valid), 32'd0);
    resp(2'b01, 2'd0, 2'd1, 8'd9, 2'd0, 2'd0, 8'd0);
    chk("s1_valid_done", 32'(bus.resp_group_valid), 32'd1);
    chk("s1_lens", bus.resp_group_match_len, 32'h0005_0907);
    bus.resp_group_ready = 1'b1;
    tick();
    bus.resp_group_ready = 1'b0;
    chk("s1_valid_after", 32'(bus.resp_group_valid), 32'd0);

    // out-of-order completion across two groups
    do_reset();
    alloc(4'b0011, 2'd0);
    alloc(4'b0011, 2'd1);
    resp(2'b11, 2'd1, 2'd0, 8'h11, 2'd1, 2'd1, 8'h12);
    chk("s2_hold_gid1", 32'(bus.resp_group_valid), 32'd0);
    resp(2'b11, 2'd0, 2'd1, 8'h21, 2'd0, 2'd0, 8'h20);
    chk("s2_gid0_valid", 32'(bus.resp_group_valid), 32'd1);
    chk("s2_gid0_lens", bus.resp_group_match_len, 32'h0000_2120);
    bus.resp_group_ready = 1'b1;
    tick();
    chk("s2_gid1_valid", 32'(bus.resp_group_valid), 32'd1);
    chk("s2_gid1_lens", bus.resp_group_match_len, 32'h0000_1211);
    tick();
    bus.resp_group_ready = 1'b0;
    chk("s2_empty", 32'(bus.resp_group_valid), 32'd0);
    chk("s2_err", 32'(bus.err), 32'd0);

    // full and pointer wrap
    do_reset();
    alloc(4'b0001, 2'd0);
    alloc(4'b0001, 2'd1);
    alloc(4'b0001, 2'd2);
    alloc(4'b0001, 2'd3);
    chk("s3_full_ready", 32'(bus.req_group_ready), 32'd0);
    chk("s3_wrap_id", 32'(bus.req_group_id), 32'd0);
    resp(2'b01, 2'd0, 2'd0, 8'h33, 2'd0, 2'd0, 8'd0);
    chk("s3_head_valid", 32'(bus.resp_group_valid), 32'd1);
    chk("s3_head_lens", bus.resp_group_match_len, 32'h0000_0033);
    bus.resp_group_ready = 1'b1;
    bus.req_group_valid  = 1'b1;
    bus.req_group_strb   = 4'b0001;
    chk("s3_no_bypass", 32'(bus.req_group_ready), 32'd0);
    tick();
    bus.resp_group_ready = 1'b0;
    bus.req_group_valid  = 1'b0;
    chk("s3_freed_ready", 32'(bus.req_group_ready), 32'd1);
    chk("s3_freed_id", 32'(bus.req_group_id), 32'd0);
    alloc(4'b0001, 2'd0);
    chk("s3_full_again", 32'(bus.req_group_ready), 32'd0);
    chk("s3_gid1_pending", 32'(bus.resp_group_valid), 32'd0);

    // empty strobe completes immediately; response to a free entry is an error
    do_reset();
    alloc(4'b0000, 2'd0);
    chk("s4_valid", 32'(bus.resp_group_valid), 32'd1);
    chk("s4_lens", bus.resp_group_match_len, 32'd0);
    resp(2'b01, 2'd3, 2'd0, 8'h66, 2'd0, 2'd0, 8'd0);
    chk("s4_unalloc_err", 32'(bus.err), 32'd1);
    chk("s4_still_valid", 32'(bus.resp_group_valid), 32'd1);

    // same gid/tag on both channels: lowest channel wins
    do_reset();
    alloc(4'b1111, 2'd0);
    resp(2'b11, 2'd0, 2'd3, 8'd3, 2'd0, 2'd3, 8'd4);
    chk("s5a_err", 32'(bus.err), 32'd1);
    resp(2'b11, 2'd0, 2'd0, 8'h10, 2'd0, 2'd1, 8'h11);
    resp(2'b01, 2'd0, 2'd2, 8'h12, 2'd0, 2'd0, 8'd0);
    chk("s5a_valid", 32'(bus.resp_group_valid), 32'd1);
    chk("s5a_lens", bus.resp_group_match_len, 32'h0312_1110);

    // duplicate slot response
    do_reset();
    alloc(4'b1111, 2'd0);
    resp(2'b01, 2'd0, 2'd1, 8'h44, 2'd0, 2'd0, 8'd0);
    chk("s5b_err_clean", 32'(bus.err), 32'd0);
    resp(2'b01, 2'd0, 2'd1, 8'h55, 2'd0, 2'd0, 8'd0);
    chk("s5b_dup_err", 32'(bus.err), 32'd1);
    resp(2'b11, 2'd0, 2'd0, 8'h01, 2'd0, 2'd2, 8'h02);
    resp(2'b01, 2'd0, 2'd3, 8'h03, 2'd0, 2'd0, 8'd0);
    chk("s5b_valid", 32'(bus.resp_group_valid), 32'd1);
    chk("s5b_lens", bus.resp_group_match_len, 32'h0302_4401);
    tick();
    chk("s5b_err_sticky", 32'(bus.err), 32'd1);

    // backpressure stability, then reset mid-operation
    do_reset();
    alloc(4'b0001, 2'd0);
    resp(2'b01, 2'd0, 2'd0, 8'h5a, 2'd0, 2'd0, 8'd0);
    resp(2'b01, 2'd0, 2'd0, 8'h77, 2'd0, 2'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("s6_bp_valid", 32'(bus.resp_group_valid), 32'd1);
      chk("s6_bp_lens", bus.resp_group_match_len, 32'h0000_005a);
      tick();
    end
    chk("s6_err_set", 32'(bus.err), 32'd1);
    bus.req_group_valid = 1'b1;
    bus.req_group_strb  = 4'b1111;
    bus.resp_valid      = 2'b01;
    bus.resp_gid        = '0;
    bus.resp_tag        = 4'b0001;
    bus.resp_match_len  = 16'h0099;
    rst = 1'b1;
    tick();
    chk("s6_rst_count", 32'(dut.count), 32'd0);
    chk("s6_rst_valid", 32'(bus.resp_group_valid), 32'd0);
    chk("s6_rst_err", 32'(bus.err), 32'd0);
    chk("s6_rst_id", 32'(bus.req_group_id), 32'd0);
    chk("s6_rst_ready", 32'(bus.req_group_ready), 32'd1);
    rst = 1'b0;
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/match_resp_reorder.md
# match_resp_reorder

Multi-outstanding successor to the single-group match response collector. It tracks up to D in-flight lazy-match request groups per job PE. Each group has L slots and is tagged with a group ID. The block collects responses from C match channels in any order and across groups, then releases completed groups to the job PE strictly in allocation order. It sits between the match request dispatcher, which allocates groups and tags requests, and `job_pe`.

## Interface
- `JOB_PE_IDX`, 0: owning job PE index; used only in debug logs.
- `L`, `LAZY_LEN`: slots per group.
- `C`, `NUM_MATCH_REQ_CH`: response channels.
- `D`, 4: outstanding group entries; power of two, ≥2.
- `TAG_BITS`, `LAZY_LEN_LOG2`: slot tag width.
- `GID_BITS`, $clog2(D): group ID width.
- `ML`, `MATCH_LEN_WIDTH`: match length width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_group_valid` in 1: dispatcher requests a new group entry.
- `req_group_ready` out 1: an entry is free.
- `req_group_strb` in L: slots actually requested; a 0 slot counts as done.
- `req_group_id` out GID_BITS: ID assigned to the entry on fire (current tail).
- `resp_valid` in C: per-channel response valid.
- `resp_ready` out C: per-channel accept.
- `resp_gid` in C*GID_BITS: group ID per channel.
- `resp_tag` in C*TAG_BITS: slot per channel.
- `resp_match_len` in C*ML: match length per channel.
- `resp_group_valid` out 1: head group complete.
- `resp_group_ready` in 1: job PE accepts the group.
- `resp_group_match_len` out L*ML: lengths of the head group.
- `err` out 1: sticky protocol error flag.

## Operation
- State: D entries, each holding `done[L]`, `len[L*ML]` and `alloc`. Also head and tail pointers (GID_BITS wide, natural wrap) and `count` (0..D, GID_BITS+1 bits).
- Allocate on `req_group_valid & req_group_ready`:
  - entry[tail].done ← ~strb, len ← 0, alloc ← 1.
  - tail += 1.
  - `req_group_id` = tail before the increment.
- Accept responses:
  - `resp_ready` = all ones; the block never stalls channels.
  - A response on channel j is legal iff entry[gid].alloc and !entry[gid].done[tag].
  - A legal response sets done[tag] and writes len[tag] = match_len.
- Error cases set `err`:
  - Illegal response (unallocated entry or slot already done): no state change.
  - Two channels hitting the same gid/tag in one cycle: the lowest channel index wins.
- Release:
  - `resp_group_valid` = count≠0 & &entry[head].done.
  - `resp_group_match_len` = entry[head].len.
  - On fire: alloc[head] ← 0, head += 1.
- `count` updates: +1 on alloc only, −1 on release only, unchanged when both occur.
- Full (count==D): `req_group_ready`=0. No same-cycle bypass; a freed entry becomes allocatable the next cycle.
- Empty (count==0): `resp_group_valid`=0.
- A strobe of all zeros produces a group complete on the next cycle with all lengths 0.
- Reset (any cycle, including mid-operation) clears:
  - all entries' alloc, done and len;
  - head, tail, count;
  - `err`.
  - In-flight responses are discarded; upstream must reset together with this block.
- Reset output values: `req_group_ready`=1, `req_group_id`=0, `resp_group_valid`=0, `resp_group_match_len`=0, `err`=0, `resp_ready`=all ones.

## Timing
- Response accepted in cycle t: done/len are visible at t+1. If that completes the head, `resp_group_valid` is high at t+1.
- Allocation in cycle t: the entry is addressable by responses from t+1. A response to it in cycle t is an error.
- `resp_group_valid` and data are held stable until `resp_group_ready`. Release to the next complete head is possible back-to-back, at one group per cycle.
- A response to the group being released in the same cycle is necessarily a duplicate and therefore an error.
- All outputs are functions of registers only; there is no combinational in→out path except `resp_ready`, which is constant.

## Structure
- Shared package/header (`parameters.vh`) supplies `LAZY_LEN`, `LAZY_LEN_LOG2`, `NUM_MATCH_REQ_CH`, `MATCH_LEN_WIDTH`. Add `MATCH_RESP_DEPTH` (default D) there.
- Sub-module `match_resp_entry` (one per entry), with:
  - inputs: alloc/strb, release, C-wide hit vector with lengths;
  - outputs: done vector, lens, alloc, per-channel legality.
- The top level holds the pointers, count, channel decode with per-channel lowest-index priority, head mux, and `err`.
- Debug `$display` under `JOB_PE_DEBUG_LOG`, tagged by `JOB_PE_IDX`.

## Test plan
All scenarios use L=4, C=2, D=4, ML=8.
- Single group, strb=1111. Responses arrive in the order (tag2,len5), (tag0,7), (tag3,0), (tag1,9), one per cycle. Required: `resp_group_valid` high exactly 1 cycle after the last response, with lens {0:7, 1:9, 2:5, 3:0}.
- Out-of-order groups:
  - Allocate gid0 and gid1, each with strb=0011.
  - Complete gid1 first. Required: no output.
  - Complete gid0. Required: gid0 is emitted, then gid1 on the next cycle with `resp_group_ready` held 1.
- Full/wrap: allocate 4 groups. Required: `req_group_ready`=0. Release one; the next allocation gets `req_group_id`=0 one cycle later.
- strb=0000. Required: group valid the cycle after allocation, all lens 0.
- Errors:
  - Duplicate slot response. Required: `err` rises next cycle and stays; the stored len is unchanged.
  - Both channels hitting the same gid/tag (ch0 len 3, ch1 len 4). Required: len=3, `err`=1.
- Backpressure and reset: with `resp_group_ready`=0 for 5 cycles, output is stable. Then assert `rst` mid-operation. Required: the next cycle shows count 0, `resp_group_valid`=0, `err`=0, `req_group_id`=0.
